// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one request/acknowledge memory bus between the instruction-fetch
// port (i_*) and the data port (d_*). One transaction is open at a time;
// bus outputs are registered and held constant until m_ack.
//
// Ports
//   clk, rst        : clock, asynchronous active-low reset
//   i_req/i_addr    : instruction read request and address
//   i_rdata/i_stall : instruction read data, stall to the fetch stage
//   d_req/d_we/d_wstrb/d_addr/d_wdata : data request
//   d_rdata/d_stall : data read data, stall to the memory stage
//   m_req/m_we/m_wstrb/m_addr/m_wdata : registered bus request
//   m_rdata/m_ack   : bus read data and single-cycle completion pulse
//
// Build option
//   MEM_ARB_RR_EN : defined -> round-robin tie break between the ports,
//                   undefined -> data port always wins a tie.
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_req,
   input  logic [AW-1:0]   i_addr,
   output logic [DW-1:0]   i_rdata,
   output logic            i_stall,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [DW/8-1:0] d_wstrb,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   output logic [DW-1:0]   d_rdata,
   output logic            d_stall,
   output logic            m_req,
   output logic            m_we,
   output logic [DW/8-1:0] m_wstrb,
   output logic [AW-1:0]   m_addr,
   output logic [DW-1:0]   m_wdata,
   input  logic [DW-1:0]   m_rdata,
   input  logic            m_ack
);

   typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} stateT;

   stateT state, nextState;
   logic  iDone, dDone;
   logic  lastD;        // port served last: 0 = instruction, 1 = data
   logic  iElig, dElig;
   logic  tieWinD;
   logic  grantI, grantD;
   logic  busAck;

   // A port whose done pulse is high has just been served and must not be
   // re-granted for the same (still held) request.
   assign iElig   = i_req & ~iDone;
   assign dElig   = d_req & ~dDone;
   assign i_stall = i_req & ~iDone;
   assign d_stall = d_req & ~dDone;

`ifdef MEM_ARB_RR_EN
   assign tieWinD = ~lastD;
`else
   // lastD is tracked in both builds; with fixed priority it never
   // changes the outcome of a tie.
   assign tieWinD = lastD | 1'b1;
`endif

   always_comb begin
      nextState = state;
      grantI    = 1'b0;
      grantD    = 1'b0;
      busAck    = 1'b0;
      case (state)
         IDLE: begin
            if (iElig && dElig) begin
               grantD = tieWinD;
               grantI = ~tieWinD;
            end else begin
               grantD = dElig;
               grantI = iElig;
            end
            if (grantD)      nextState = DBUSY;
            else if (grantI) nextState = IBUSY;
         end
         IBUSY, DBUSY: begin
            if (m_ack) begin
               busAck    = 1'b1;
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_req   <= 1'b0;
         m_we    <= 1'b0;
         m_wstrb <= '0;
         m_addr  <= '0;
         m_wdata <= '0;
         i_rdata <= '0;
         d_rdata <= '0;
         iDone   <= 1'b0;
         dDone   <= 1'b0;
         lastD   <= 1'b0;
      end else begin
         // Done flags are single-cycle pulses.
         iDone <= 1'b0;
         dDone <= 1'b0;
         if (grantD) begin
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_wstrb <= d_we ? d_wstrb : '0;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            lastD   <= 1'b1;
         end else if (grantI) begin
            m_req   <= 1'b1;
            m_we    <= 1'b0;
            m_wstrb <= '0;
            m_addr  <= i_addr;
            lastD   <= 1'b0;
         end else if (busAck) begin
            m_req <= 1'b0;
            if (state == IBUSY) begin
               i_rdata <= m_rdata;
               iDone   <= 1'b1;
            end else begin
               if (!m_we) d_rdata <= m_rdata;
               dDone <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter for the MIPS SoC. Shares one request/acknowledge memory bus between the fetch stage (instruction port) and the memory stage (data port). Each port sees a stall signal that the hazard logic feeds into the pipeline's stall inputs. Transactions are serialized through a three-state FSM with registered bus outputs.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width; byte strobes are `DW/8` bits.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  reset; one clock, asynchronous, active-low.
- `i_req`  in  1  instruction read request, held until `i_stall` is low.
- `i_addr`  in  AW  instruction address.
- `i_rdata`  out  DW  instruction read data, valid while `i_done`=1.
- `i_stall`  out  1  = `i_req & ~i_done`.
- `d_req`  in  1  data request, held until `d_stall` is low.
- `d_we`  in  1  1=write, 0=read.
- `d_wstrb`  in  DW/8  byte enables for writes.
- `d_addr`  in  AW  data address.
- `d_wdata`  in  DW  write data.
- `d_rdata`  out  DW  read data, valid while `d_done`=1.
- `d_stall`  out  1  = `d_req & ~d_done`.
- `m_req`  out  1  bus request, held until `m_ack`.
- `m_we`  out  1  bus write.
- `m_wstrb`  out  DW/8  bus strobes; all zeros for reads.
- `m_addr`  out  AW  bus address.
- `m_wdata`  out  DW  bus write data.
- `m_rdata`  in  DW  bus read data, sampled when `m_ack`=1.
- `m_ack`  in  1  bus completion, a single-cycle pulse; ignored when `m_req`=0.

## Operation
- FSM states:
  - `IDLE`: no bus transaction open.
  - `IBUSY`: instruction transaction open.
  - `DBUSY`: data transaction open.
- Internal registers:
  - `i_done`, `d_done`: one-cycle completion pulses.
  - `last`: port served last; 0=I, 1=D.
- In `IDLE`, a port is eligible when its req=1 and its done=0. A port whose done pulse is high cannot be re-granted that same cycle.
- Grant rule when only one port is eligible: that port.
- Grant rule when both are eligible: see Configuration.
- On grant, the next state is `IBUSY`/`DBUSY`. In the same edge:
  - Latch address, `we`, strobes and wdata into the `m_*` registers.
  - Set `m_req`=1.
  - Update `last`.
- Instruction grant drives `m_we`=0 and `m_wstrb`=0.
- In `IBUSY`/`DBUSY`:
  - `m_*` outputs are held constant until `m_ack`.
  - On `m_ack`: capture `m_rdata` into the port's rdata register (reads only; writes leave it unchanged), clear `m_req`, set that port's done=1, go to `IDLE`.
- Done pulses clear on the following edge.
- Port inputs are not re-sampled during BUSY. A requester that drops req mid-transaction does not abort it; the done pulse still occurs.
- `i_rdata`/`d_rdata` hold their last captured value until the next read on that port.

## Timing
- Reset values:
  - State `IDLE`.
  - `m_req`=0, `m_we`=0, `m_wstrb`=0, `m_addr`=0, `m_wdata`=0.
  - `i_rdata`=0, `d_rdata`=0.
  - `i_done`=0, `d_done`=0, `last`=0.
- Stalls are combinational from req and done.
- Reset assertion mid-transaction abandons it: `m_req` falls asynchronously and no done pulse is generated.
- Zero-wait bus latency:
  - Cycle 0: req seen in `IDLE`.
  - Cycle 1: `m_req`=1 and `m_ack`=1.
  - Cycle 2: done=1 and stall=0. The requester advances at the end of cycle 2.
  - Minimum 3 cycles per access; N bus wait cycles add N.
- Back-to-back: in a port's done cycle the other port may be granted. Worst-case wait for a port is one full transaction of the other port.
- `m_ack` while in `IDLE` is ignored. No state change and no capture occur.

## Configuration
- `MEM_ARB_RR_EN` defined: when both ports are eligible in `IDLE`, grant the port not in `last`. After reset `last`=0, so D wins the first tie.
- `MEM_ARB_RR_EN` undefined: D always wins ties (fixed priority). `last` is still maintained but not used.

## Test plan
- Reset, then D read of `0x100`, bus acks in the cycle after `m_req` rises with `0xDEADBEEF` -> `m_req` high 1 cycle, `d_stall` high 2 cycles, `d_rdata`=`0xDEADBEEF` with `d_done`=1 in cycle 2.
- D write `0x40`, `wstrb`=`4'b0011`, `wdata`=`0x12345678`, 3 bus wait cycles -> `m_*` stable for 4 cycles, `d_stall` low in cycle 5, `d_rdata` unchanged.
- `i_req` and `d_req` both held high, each access zero-wait:
  - Fixed priority: D first, then I granted in D's done cycle.
  - RR: grants alternate D, I, D, I across 4 transactions.
- I read in progress, `rst` pulled low mid-wait -> `m_req`=0 immediately, state `IDLE`, no `i_done` after release.
- `i_req` held high through its done cycle -> no second bus request for the same fetch until the requester changes state. `m_ack` pulsed in `IDLE` -> no state change.
